// File: rtl/load_data_extender_pkg.sv
// -----------------------------------------------------------------------------
// load_data_extender_pkg
//
// Shared definitions for the load-path back end:
//   - MIPS load opcodes (OPCODE_*)
//   - load_kind_t : decoded load class stored in the metadata FIFO
//   - load_meta_t : per-load metadata record {kind, is_signed, offset, rt, dest}
//   - decode helpers used at request-push time
//
// Configuration macro: UNALIGNED_LOAD_EN
//   defined     -> load_meta_t carries the 32-bit rt value for LWL/LWR merging
//   not defined -> rt field omitted (record narrower by 32 bits)
// -----------------------------------------------------------------------------
package load_data_extender_pkg;

    // Primary opcode field values for loads
    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LWL = 6'h22;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_LWR = 6'h26;

    // Destination tag storage width inside the record; the top-level
    // TAG_WIDTH parameter must not exceed this.
    localparam int META_DEST_WIDTH = 8;

    typedef enum logic [2:0] {
        LK_BYTE  = 3'd0,
        LK_HALF  = 3'd1,
        LK_WORD  = 3'd2,
        LK_LEFT  = 3'd3,
        LK_RIGHT = 3'd4
    } load_kind_t;

    typedef struct packed {
        load_kind_t                 kind;
        logic                       is_signed;
        logic [1:0]                 offset;
`ifdef UNALIGNED_LOAD_EN
        logic [31:0]                rt;
`endif
        logic [META_DEST_WIDTH-1:0] dest;
    } load_meta_t;

    // Opcode -> load class; anything unrecognised is treated as a word load
    function automatic load_kind_t decode_kind(input logic [5:0] opcode);
        load_kind_t kind;
        case (opcode)
            OPCODE_LB, OPCODE_LBU: kind = LK_BYTE;
            OPCODE_LH, OPCODE_LHU: kind = LK_HALF;
            OPCODE_LW:             kind = LK_WORD;
            OPCODE_LWL:            kind = LK_LEFT;
            OPCODE_LWR:            kind = LK_RIGHT;
            default:               kind = LK_WORD;
        endcase
        return kind;
    endfunction

    // Only LB and LH sign-extend
    function automatic logic decode_signed(input logic [5:0] opcode);
        logic is_signed;
        case (opcode)
            OPCODE_LB, OPCODE_LH: is_signed = 1'b1;
            default:              is_signed = 1'b0;
        endcase
        return is_signed;
    endfunction

endpackage

// File: rtl/load_data_extender_fifo.sv
// -----------------------------------------------------------------------------
// load_meta_fifo
//
// In-order metadata FIFO for outstanding loads. Pointers are log2(DEPTH)
// bits plus a wrap bit: equal pointers mean empty, pointers differing only
// in the wrap bit mean full. Push while full and pop while empty are ignored.
// No pass-through: a push is only visible at the head from the next cycle.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   push, push_meta  write one record (ignored when full)
//   pop              discard head record (ignored when empty)
//   head_meta        current head record
//   full, empty      occupancy flags
// -----------------------------------------------------------------------------
module load_meta_fifo
    import load_data_extender_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  load_meta_t push_meta,
    input  logic       pop,
    output load_meta_t head_meta,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    load_meta_t  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_push_s;
    logic        do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head_meta = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset flushes all outstanding entries
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents are qualified by the pointers so need no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_meta;
        end
    end

endmodule

// File: rtl/load_data_extender.sv
// -----------------------------------------------------------------------------
// load_data_extender
//
// Load-path back end of the data-memory interface. Records metadata for each
// issued load in an in-order FIFO, pairs every memory read response with the
// oldest outstanding load, and produces the register writeback value:
// byte/halfword extraction with sign/zero extension, word passthrough and
// LWL/LWR merging with the old rt contents.
//
// Configuration macro: UNALIGNED_LOAD_EN
//   defined     -> LWL/LWR merge with rt; rt is stored per load
//   not defined -> LWL/LWR behave as LW (misaligned when offset != 0),
//                  req_rt_value is unused
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     load issue handshake (ready = FIFO not full)
//   req_opcode          load opcode
//   req_byte_offset     address[1:0]
//   req_rt_value        rt contents for LWL/LWR
//   req_dest            destination register tag
//   mem_readdatavalid   read response strobe
//   mem_readdata        aligned response word
//   resp_valid          one-cycle writeback strobe, one cycle after response
//   resp_data           extended/merged result
//   resp_dest           tag of completed load
//   resp_misaligned     completed load used an illegal offset
//   protocol_error      sticky: response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module load_data_extender
    import load_data_extender_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 5     // must be <= META_DEST_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_opcode,
    input  logic [1:0]           req_byte_offset,
    input  logic [31:0]          req_rt_value,
    input  logic [TAG_WIDTH-1:0] req_dest,
    input  logic                 mem_readdatavalid,
    input  logic [31:0]          mem_readdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_data,
    output logic [TAG_WIDTH-1:0] resp_dest,
    output logic                 resp_misaligned,
    output logic                 protocol_error
);

    load_meta_t push_meta_s;
    load_meta_t head_meta_s;
    logic       full_s;
    logic       empty_s;
    logic       push_s;
    logic       pop_s;
    logic       stray_s;

    logic [31:0] result_s;
    logic        misaligned_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    logic                 resp_valid_r;
    logic [31:0]          resp_data_r;
    logic [TAG_WIDTH-1:0] resp_dest_r;
    logic                 resp_misaligned_r;
    logic                 protocol_error_r;

    // Collects bits that are intentionally not consumed in every build
    logic unused_s;
`ifdef UNALIGNED_LOAD_EN
    assign unused_s = ^head_meta_s.dest;
`else
    assign unused_s = ^{head_meta_s.dest, req_rt_value};
`endif

    assign req_ready = !full_s;
    assign push_s    = req_valid && !full_s;
    // A same-cycle push is not yet at the head, so an empty FIFO makes any
    // response a stray even if a request is being accepted right now.
    assign pop_s     = mem_readdatavalid && !empty_s;
    assign stray_s   = mem_readdatavalid && empty_s;

    // Decode opcode once at issue so the FIFO only holds the load class
    always_comb begin
        push_meta_s           = '0;
        push_meta_s.kind      = decode_kind(req_opcode);
        push_meta_s.is_signed = decode_signed(req_opcode);
        push_meta_s.offset    = req_byte_offset;
`ifdef UNALIGNED_LOAD_EN
        push_meta_s.rt        = req_rt_value;
`endif
        push_meta_s.dest      = META_DEST_WIDTH'(req_dest);
    end

    load_meta_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_meta (push_meta_s),
        .pop       (pop_s),
        .head_meta (head_meta_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Extract / extend / merge the returned word according to the head load
    always_comb begin
        result_s     = mem_readdata;
        misaligned_s = 1'b0;
        byte_s       = 8'h00;
        half_s       = 16'h0000;
        case (head_meta_s.kind)
            LK_BYTE: begin
                case (head_meta_s.offset)
                    2'd0:    byte_s = mem_readdata[7:0];
                    2'd1:    byte_s = mem_readdata[15:8];
                    2'd2:    byte_s = mem_readdata[23:16];
                    default: byte_s = mem_readdata[31:24];
                endcase
                if (head_meta_s.is_signed) begin
                    result_s = {{24{byte_s[7]}}, byte_s};
                end else begin
                    result_s = {24'h000000, byte_s};
                end
            end
            LK_HALF: begin
                // offset[0] only flags the fault; lane pair comes from offset[1]
                if (head_meta_s.offset[1]) begin
                    half_s = mem_readdata[31:16];
                end else begin
                    half_s = mem_readdata[15:0];
                end
                if (head_meta_s.is_signed) begin
                    result_s = {{16{half_s[15]}}, half_s};
                end else begin
                    result_s = {16'h0000, half_s};
                end
                misaligned_s = head_meta_s.offset[0];
            end
`ifdef UNALIGNED_LOAD_EN
            LK_LEFT: begin
                // (readdata << 8*(3-k)) | (rt & low (3-k) bytes)
                case (head_meta_s.offset)
                    2'd0:    result_s = {mem_readdata[7:0],  head_meta_s.rt[23:0]};
                    2'd1:    result_s = {mem_readdata[15:0], head_meta_s.rt[15:0]};
                    2'd2:    result_s = {mem_readdata[23:0], head_meta_s.rt[7:0]};
                    default: result_s = mem_readdata;
                endcase
            end
            LK_RIGHT: begin
                // (readdata >> 8*k) | (rt & high k bytes)
                case (head_meta_s.offset)
                    2'd0:    result_s = mem_readdata;
                    2'd1:    result_s = {head_meta_s.rt[31:24], mem_readdata[31:8]};
                    2'd2:    result_s = {head_meta_s.rt[31:16], mem_readdata[31:16]};
                    default: result_s = {head_meta_s.rt[31:8],  mem_readdata[31:24]};
                endcase
            end
`endif
            default: begin
                // LW, unknown opcodes, and LWL/LWR when merging is disabled
                result_s     = mem_readdata;
                misaligned_s = (head_meta_s.offset != 2'd0);
            end
        endcase
    end

    // Registered writeback outputs and sticky protocol error
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r      <= 1'b0;
            resp_data_r       <= 32'h0000_0000;
            resp_dest_r       <= {TAG_WIDTH{1'b0}};
            resp_misaligned_r <= 1'b0;
            protocol_error_r  <= 1'b0;
        end else begin
            resp_valid_r <= pop_s;
            if (pop_s) begin
                resp_data_r       <= result_s;
                resp_dest_r       <= head_meta_s.dest[TAG_WIDTH-1:0];
                resp_misaligned_r <= misaligned_s;
            end
            if (stray_s) begin
                protocol_error_r <= 1'b1;
            end
        end
    end

    assign resp_valid      = resp_valid_r;
    assign resp_data       = resp_data_r;
    assign resp_dest       = resp_dest_r;
    assign resp_misaligned = resp_misaligned_r;
    assign protocol_error  = protocol_error_r;

endmodule

// File: doc/load_data_extender.md
# load_data_extender

Load-path back end of the MIPS data-memory interface. Tracks up to DEPTH outstanding loads, pairs each memory read response with its request metadata in order, and produces the architecturally correct register value. Covers byte/halfword extraction, sign or zero extension, and LWL/LWR merging. Sits between the memory-read issue logic and register-file writeback; it replaces the old immediate-only extension on the load path.

## Interface
Parameters:
- DEPTH, 4, maximum outstanding loads; power of two, ≥2
- TAG_WIDTH, 5, width of destination-register tag carried with each load

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  load issued to memory this cycle
- req_ready  out  1  request slot available; equals !full
- req_opcode  in  6  load opcode (LB, LH, LWL, LW, LBU, LHU, LWR)
- req_byte_offset  in  2  address[1:0] of the load
- req_rt_value  in  32  current rt contents; used only by LWL/LWR
- req_dest  in  TAG_WIDTH  destination register tag
- mem_readdatavalid  in  1  memory returns read data this cycle
- mem_readdata  in  32  returned aligned word; byte lane k = readdata[8k+7:8k]
- resp_valid  out  1  writeback value valid (single-cycle pulse)
- resp_data  out  32  extended/merged load result
- resp_dest  out  TAG_WIDTH  tag of completed load
- resp_misaligned  out  1  completed load had an illegal offset
- protocol_error  out  1  sticky; readdatavalid arrived with no outstanding load

## Operation
- Request accepted when req_valid && req_ready. The block pushes {opcode, byte_offset, rt_value, dest} into an in-order metadata FIFO.
- On mem_readdatavalid, the FIFO head is popped and combined with mem_readdata:
  - LB/LBU: lane = offset; sign/zero extend 8→32.
  - LH/LHU: lane pair = offset[1] (bits [15:0] or [31:16]); sign/zero extend 16→32. Odd offset → resp_misaligned=1, offset[0] ignored.
  - LW: data passthrough. Offset≠0 → resp_misaligned=1.
  - LWL (offset k): (readdata << 8·(3−k)) | (rt & low-(3−k)-byte mask).
  - LWR (offset k): (readdata >> 8·k) | (rt & high-k-byte mask).
  - Any other opcode is handled as LW and flagged misaligned only if offset≠0.
- Empty FIFO with mem_readdatavalid: response ignored, no resp_valid, protocol_error set until reset.
- Push and pop in the same cycle: occupancy unchanged; both take effect.
- Full: req_ready=0, so no push. A pop in that cycle raises req_ready the following cycle; there is no same-cycle pass-through.
- Reset mid-operation: FIFO flushed; pending responses discarded. Any readdatavalid after reset counts as a protocol error.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_dest=0, resp_misaligned=0, protocol_error=0, occupancy=0.
- Latency: readdatavalid in cycle N → resp_valid/resp_data/resp_dest/resp_misaligned registered, visible in cycle N+1 for exactly one cycle.
- Throughput: one response per cycle; one request per cycle while not full.
- A request accepted in cycle N can be matched by readdatavalid in cycle N+1 at the earliest. Same-cycle request/response pairing of that request is not supported; a same-cycle pop serves the older head.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full = pointers differ only in the wrap bit; empty = pointers equal.

## Configuration
- UNALIGNED_LOAD_EN defined: LWL/LWR merge as specified; req_rt_value is stored in the FIFO.
- Not defined: rt storage is omitted (FIFO narrower by 32 bits); LWL/LWR are handled as LW with resp_misaligned=(offset≠0); req_rt_value is unused.

## Structure
- Shared package: existing OPCODE_* constants plus new OPCODE_LH, OPCODE_LHU, OPCODE_LWL, OPCODE_LWR.
- Also in the package: typedef enum load_kind_t {LK_BYTE, LK_HALF, LK_WORD, LK_LEFT, LK_RIGHT}, and typedef struct load_meta_t {kind, is_signed, offset, rt, dest}.
- The opcode → load_kind_t decode happens at push, so the FIFO stores decoded kind, not opcode.
- Sub-module: load_meta_fifo (parametrised DEPTH, synchronous-reset, in-order, full/empty flags). Extraction/merge logic stays in the top.

## Test plan
- LB offset 3, readdata=0x80_12_34_56 → resp_data=0xFFFFFF80. LBU same → 0x00000080. resp_valid one cycle after readdatavalid.
- LH offset 2, readdata=0x8001_7FFF → 0xFFFF8001. LHU offset 0 → 0x00007FFF. LH offset 1 → resp_misaligned=1.
- LWL offset 1, rt=0xAABBCCDD, readdata=0x11223344 → 0x3344CCDD. LWR offset 1 → 0xAA112233. With UNALIGNED_LOAD_EN undefined: LWL offset 1 → 0x11223344, misaligned=1.
- Issue DEPTH loads with no responses → req_ready=0. Then readdatavalid + req_valid in the same cycle → req_ready=1 next cycle. Responses return in issue order with the correct resp_dest tags.
- readdatavalid with FIFO empty → no resp_valid; protocol_error=1 and held. Assert reset with 2 loads outstanding → all outputs return to reset values, occupancy=0.
